seg_scan: RTL and testbench

//  Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.
//  - Consumes the 20-bit packed glyph word from the banner/help stage: 4 x 5-bit codes, bits[19:15] leftmost.
//  - Snapshots the word once per frame, scans the digits, decodes the codes to segments and applies per-digit blink.
//  - Drives the FPGA display pins directly.

---
 rtl/seg_pkg.sv | 57 +++++
 rtl/seg_scan_if.sv | 10 +
 rtl/seg_glyph_rom.sv | 9 +
 rtl/seg_scan.sv | 79 +++++++
 tb/tb_seg_scan.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph codes, active-low segment patterns and
// the code-to-segment decode used by every display driver on the board.
package seg_pkg;

   localparam logic [4:0] CODE_BLANK = 5'd31;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [7:0] SEG_DASH   = 8'hBF;

   // {dp,g,f,e,d,c,b,a}, active-low, dp always off
   localparam logic [7:0] G_0 = 8'hC0, G_1 = 8'hF9, G_2 = 8'hA4, G_3 = 8'hB0;
   localparam logic [7:0] G_4 = 8'h99, G_5 = 8'h92, G_6 = 8'h82, G_7 = 8'hF8;
   localparam logic [7:0] G_8 = 8'h80, G_9 = 8'h90, G_A = 8'h88, G_B = 8'h83;
   localparam logic [7:0] G_C = 8'hC6, G_D = 8'hA1, G_E = 8'h86, G_F = 8'h8E;
   localparam logic [7:0] G_H = 8'h89, G_N = 8'hAB, G_L = 8'hC7, G_O = 8'hA3;
   localparam logic [7:0] G_P = 8'h8C, G_R = 8'hAF, G_U = 8'hC1, G_T = 8'h87;
   localparam logic [7:0] G_Y = 8'h91, G_MINUS = 8'hBF, G_UNDER = 8'hF7;

   typedef struct packed {
      logic [19:0] code;
      logic [3:0]  blink;
   } frame_t;

   function automatic logic [7:0] seg_glyph(input logic [4:0] code);
      case (code)
         5'd0:  return G_0;
         5'd1:  return G_1;
         5'd2:  return G_2;
         5'd3:  return G_3;
         5'd4:  return G_4;
         5'd5:  return G_5;
         5'd6:  return G_6;
         5'd7:  return G_7;
         5'd8:  return G_8;
         5'd9:  return G_9;
         5'd10: return G_A;
         5'd11: return G_B;
         5'd12: return G_C;
         5'd13: return G_D;
         5'd14: return G_E;
         5'd15: return G_F;
         5'd16: return G_H;
         5'd17: return G_N;
         5'd18: return G_L;
         5'd19: return G_O;
         5'd20: return G_P;
         5'd21: return G_R;
         5'd22: return G_U;
         5'd23: return G_T;
         5'd24: return G_Y;
         5'd25: return G_MINUS;
         5'd26: return G_UNDER;
         CODE_BLANK: return SEG_BLANK;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display bundle between the glyph source (master) and the scan driver (slave).
interface seg_scan_if;
   logic [19:0] disp_code;
   logic [3:0]  blink;
   logic [3:0]  an;
   logic [7:0]  seg;

   modport master (output disp_code, blink, input an, seg);
   modport slave  (input disp_code, blink, output an, seg);
endinterface

// File: rtl/seg_glyph_rom.sv
// Combinational 5-bit glyph code to active-low segment decode.
module seg_glyph_rom
   import seg_pkg::*;
(
   input  logic [4:0] code,
   output logic [7:0] seg
);
   assign seg = seg_glyph(code);
endmodule

// File: rtl/seg_scan.sv
// 4-digit common-anode scan driver: per-frame snapshot of the code word,
// digit multiplexing, glyph decode and per-digit blink.
module seg_scan
   import seg_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_TICKS = 1000
) (
   input logic        clk,
   input logic        rst_n,
   seg_scan_if.slave  bus
);
   localparam int DIV_W   = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [DIV_W-1:0]   div_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_ph;
   logic [1:0]         idx;
   frame_t             frame;
   logic [3:0]         an_q;
   logic [7:0]         seg_q;

   logic       tick;
   logic       blink_wrap;
   logic       next_ph;
   logic [1:0] next_idx;
   frame_t     next_frame;
   logic [4:0] rom_code;
   logic [7:0] rom_seg;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      tick       = (div_cnt == DIV_W'(SCAN_DIV - 1));
      next_idx   = idx + 2'd1;
      next_frame = frame;
      if (idx == 2'd3) begin
         next_frame.code  = bus.disp_code;
         next_frame.blink = bus.blink;
      end
      blink_wrap = (blink_cnt == BLINK_W'(BLINK_TICKS - 1));
      next_ph    = blink_wrap ? ~blink_ph : blink_ph;
      // Decode from the post-tick snapshot so an and seg always move together.
      rom_code   = next_frame.code[5*next_idx +: 5];
   end

   seg_glyph_rom u_rom (
      .code (rom_code),
      .seg  (rom_seg)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         blink_cnt   <= '0;
         blink_ph    <= 1'b0;
         idx         <= 2'd3;
         frame.code  <= {4{CODE_BLANK}};
         frame.blink <= 4'h0;
         an_q        <= 4'hF;
         seg_q       <= SEG_BLANK;
      end else if (tick) begin
         div_cnt   <= '0;
         idx       <= next_idx;
         frame     <= next_frame;
         blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
         blink_ph  <= next_ph;
         an_q      <= ~(4'b0001 << next_idx);
         seg_q     <= (next_ph && next_frame.blink[next_idx]) ? SEG_BLANK : rom_seg;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed + randomized bench for seg_scan against a tick-level reference model.
module tb_seg_scan;
   localparam int SCAN_DIV    = 4;
   localparam int BLINK_TICKS = 2;
   localparam logic [19:0] HELP  = {5'd16, 5'd14, 5'd18, 5'd20};
   localparam logic [19:0] BLANK = {4{5'd31}};
   localparam logic [7:0] GLYPH [32] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
      8'h89, 8'hAB, 8'hC7, 8'hA3, 8'h8C, 8'hAF, 8'hC1, 8'h87,
      8'h91, 8'hBF, 8'hF7, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hFF};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   seg_scan_if bus ();

   seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_TICKS(BLINK_TICKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int edges  = 0;
   int ticks  = 0;
   logic [19:0] snap_code  = BLANK;
   logic [3:0]  snap_blink = 4'h0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
   endtask

   // One clock: advance the model by what the specification says happens at
   // this edge, then compare outputs 1 time unit later.
   task automatic step();
      int n;
      logic [7:0] exp_an;
      logic [7:0] exp_seg;
      @(posedge clk);
      edges++;
      if (edges % SCAN_DIV == 0) begin
         ticks++;
         if ((ticks - 1) % 4 == 0) begin
            snap_code  = bus.disp_code;
            snap_blink = bus.blink;
         end
      end
      #1;
      if (ticks == 0) begin
         exp_an  = 8'h0F;
         exp_seg = 8'hFF;
      end else begin
         n       = (ticks - 1) % 4;
         exp_an  = {4'h0, ~(4'b0001 << n)};
         if (((ticks / BLINK_TICKS) % 2 == 1) && snap_blink[n])
            exp_seg = 8'hFF;
         else
            exp_seg = GLYPH[snap_code[5*n +: 5]];
      end
      check("an", {4'h0, bus.an}, exp_an);
      check("seg", bus.seg, exp_seg);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_an_async", {4'h0, bus.an}, 8'h0F);
      check("rst_seg_async", bus.seg, 8'hFF);
      edges      = 0;
      ticks      = 0;
      snap_code  = BLANK;
      snap_blink = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_an_hold", {4'h0, bus.an}, 8'h0F);
      check("rst_seg_hold", bus.seg, 8'hFF);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.disp_code = HELP;
      bus.blink     = 4'h0;
      #2;
      do_reset();

      // HELP scan, three frames
      run(3 * 4 * SCAN_DIV);

      // blank digits and undefined code
      bus.disp_code = {5'd31, 5'd31, 5'd31, 5'd0};
      run(2 * 4 * SCAN_DIV);
      bus.disp_code = {5'd31, 5'd27, 5'd31, 5'd0};
      run(2 * 4 * SCAN_DIV);

      // mid-frame change while digit 1 is shown
      bus.disp_code = HELP;
      run(4 * SCAN_DIV);
      for (int i = 0; i < 8 * SCAN_DIV; i++) begin
         if (ticks > 0 && (ticks - 1) % 4 == 1) break;
         step();
      end
      bus.disp_code = {5'd0, 5'd1, 5'd2, 5'd3};
      run(2 * 4 * SCAN_DIV);

      // blink
      bus.disp_code = HELP;
      bus.blink     = 4'b0001;
      run(4 * 4 * SCAN_DIV);
      bus.blink     = 4'b0110;
      run(4 * 4 * SCAN_DIV);
      bus.blink     = 4'h0;

      // reset mid-slot
      run(5);
      #2;
      do_reset();
      run(3 * 4 * SCAN_DIV);

      // long constant hold, then randomized codes and blink masks
      bus.disp_code = 20'($urandom);
      run(50 * 4 * SCAN_DIV);
      for (int i = 0; i < 50 * 4 * SCAN_DIV; i++) begin
         if ($urandom_range(0, 7) == 0) bus.disp_code = 20'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blink = 4'($urandom_range(0, 15));
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
